truth_table_sweeper: RTL and testbench

Synthesisable exhaustive-stimulus engine for N-input single-output combinational blocks; on-chip successor to our hand-written 3-input sweep benches.
- Drives every input combination in ascending order, holds each for a programmable dwell, samples the DUT output and compares it against a latched expected truth table.
- Reports error count, first failing vector and pass/fail.
- Sits between a board-level control interface (buttons/host) and the logic block under test.

---
 rtl/sweeper_pkg.sv | 17 +
 rtl/sweep_timer.sv | 35 +++
 rtl/truth_table_sweeper.sv | 162 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        APPLY,
        DONE
    } state_e;

    function automatic int timer_w(input int dwell, input int hold);
        int m;
        m = (dwell > hold) ? dwell : hold;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module sweep_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: steps all input vectors, checks a 1-bit DUT
// output against a latched truth table and reports errors.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int N_IN      = 3,
    parameter int DWELL     = 100,
    parameter int INIT_HOLD = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 first_fail_valid
);

    localparam int NUM_VEC = 2 ** N_IN;
    localparam int VW      = N_IN;
    localparam int EW      = N_IN + 1;
    localparam int TW      = timer_w(DWELL, INIT_HOLD);

    localparam logic [TW-1:0] DWELL_LD = TW'(DWELL - 1);
    localparam logic [TW-1:0] INIT_LD  =
        TW'((INIT_HOLD > 0) ? INIT_HOLD - 1 : 0);
    localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [VW-1:0]        vec_q, vec_d;
    logic [NUM_VEC-1:0]   exp_q, exp_d;
    logic [EW-1:0]        err_q, err_d;
    logic [VW-1:0]        ffv_q, ffv_d;
    logic                 ffval_q, ffval_d;
    logic                 pass_q, pass_d;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_en;
    logic                 tmr_tc;

    sweep_timer #(
        .W(TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            exp_q   <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        exp_d    = exp_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffval_d  = ffval_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_val  = DWELL_LD;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    exp_d    = expected;
                    err_d    = '0;
                    ffv_d    = '0;
                    ffval_d  = 1'b0;
                    pass_d   = 1'b0;
                    vec_d    = '0;
                    tmr_load = 1'b1;
                    if (INIT_HOLD == 0) begin
                        state_d = APPLY;
                        tmr_val = DWELL_LD;
                    end else begin
                        state_d = INIT;
                        tmr_val = INIT_LD;
                    end
                end
            end
            INIT: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (tmr_tc) begin
                    state_d  = APPLY;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LD;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (tmr_tc) begin
                    if (dut_out != exp_q[vec_q]) begin
                        err_d = err_q + EW'(1);
                        if (!ffval_q) begin
                            ffv_d   = vec_q;
                            ffval_d = 1'b1;
                        end
                    end
                    // Explicit terminal test keeps vec from wrapping to 0.
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d    = vec_q + VW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = DWELL_LD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                vec_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy             = (state_q == INIT) || (state_q == APPLY);
        done             = (state_q == DONE);
        dut_in           = (state_q == APPLY) ? vec_q : '0;
        tmr_en           = busy;
        pass             = pass_q;
        err_count        = err_q;
        first_fail_vec   = ffv_q;
        first_fail_valid = ffval_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: cycle-arithmetic reference model plus literal checks.
module tb_truth_table_sweeper;

    localparam int H  = 2;
    localparam int D  = 4;
    localparam int NV = 8;
    localparam int T  = H + NV * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [7:0] expected;
    logic       dut_out;
    logic [2:0] dut_in;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [2:0] ffv;
    logic       ffval;
    logic [7:0] dut_tab;

    logic       start1, abort1;
    logic [1:0] expected1;
    logic       dut_out1;
    logic [0:0] dut_in1;
    logic       busy1, done1, pass1;
    logic [1:0] err1;
    logic [0:0] ffv1;
    logic       ffval1;

    always #5 clk = ~clk;

    assign dut_out  = dut_tab[dut_in];
    assign dut_out1 = ~dut_in1[0];

    truth_table_sweeper #(
        .N_IN(3), .DWELL(D), .INIT_HOLD(H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(ffv), .first_fail_valid(ffval)
    );

    truth_table_sweeper #(
        .N_IN(1), .DWELL(2), .INIT_HOLD(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expected(expected1), .dut_out(dut_out1), .dut_in(dut_in1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffval1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endfunction

    // Model: m_t counts cycles since accepted start (0 = idle).
    int         m_t     = 0;
    logic [7:0] m_exp   = '0;
    int         m_err   = 0;
    int         m_ffv   = 0;
    bit         m_ffval = 0;
    bit         m_pass  = 0;
    int         m_v;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t = 0; m_err = 0; m_ffv = 0; m_ffval = 0; m_pass = 0;
        end else if (m_t == 0) begin
            if (start && !abort) begin
                m_exp = expected; m_err = 0; m_ffv = 0;
                m_ffval = 0; m_pass = 0; m_t = 1;
            end
        end else if (m_t <= T) begin
            if (abort) begin
                m_t = 0;
                m_pass = 0;
            end else begin
                if (m_t > H && (m_t - H) % D == 0) begin
                    m_v = (m_t - H) / D - 1;
                    if (dut_tab[m_v] != m_exp[m_v]) begin
                        m_err++;
                        if (!m_ffval) begin
                            m_ffv = m_v;
                            m_ffval = 1;
                        end
                    end
                end
                if (m_t == T) m_pass = (m_err == 0);
                m_t++;
            end
        end else begin
            m_t = 0;
        end
        #2;
        chk("m.dut_in", int'(dut_in),
            (m_t > H && m_t <= T) ? (m_t - H - 1) / D : 0);
        chk("m.busy", int'(busy), int'(m_t >= 1 && m_t <= T));
        chk("m.done", int'(done), int'(m_t == T + 1));
        chk("m.pass", int'(pass), int'(m_pass));
        chk("m.err_count", int'(err_count), m_err);
        chk("m.ffvec", int'(ffv), m_ffv);
        chk("m.ffvalid", int'(ffval), int'(m_ffval));
    end

    task automatic sweep_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; expected = '0; dut_tab = '0;
        start1 = 0; abort1 = 0; expected1 = 2'b01;
        repeat (3) @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.dut_in", int'(dut_in), 0);
        chk("rst.err", int'(err_count), 0);
        chk("rst.pass", int'(pass), 0);
        chk("rst.ffvalid", int'(ffval), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Majority DUT, all match.
        dut_tab = 8'hE8; expected = 8'hE8;
        sweep_start();
        to_cycle(2);  chk("s1.init_in", int'(dut_in), 0);
        chk("s1.busy", int'(busy), 1);
        to_cycle(7);  chk("s1.vec1", int'(dut_in), 1);
        to_cycle(34); chk("s1.vec7", int'(dut_in), 7);
        to_cycle(35); chk("s1.done", int'(done), 1);
        chk("s1.pass", int'(pass), 1);
        chk("s1.err", int'(err_count), 0);
        chk("s1.idle_in", int'(dut_in), 0);
        to_cycle(36); chk("s1.done_pulse", int'(done), 0);

        // Stuck-at-0 DUT.
        dut_tab = 8'h00;
        sweep_start();
        to_cycle(35); chk("s2.done", int'(done), 1);
        chk("s2.pass", int'(pass), 0);
        chk("s2.err", int'(err_count), 4);
        chk("s2.ffvec", int'(ffv), 3);
        chk("s2.ffvalid", int'(ffval), 1);
        to_cycle(37);

        // Abort during vector 1.
        dut_tab = 8'hE8;
        sweep_start();
        to_cycle(10); chk("s3.vec1", int'(dut_in), 1);
        abort = 1'b1;
        to_cycle(11); abort = 1'b0;
        chk("s3.busy", int'(busy), 0);
        chk("s3.dut_in", int'(dut_in), 0);
        to_cycle(50);
        chk("s3.pass", int'(pass), 0);
        chk("s3.err", int'(err_count), 0);

        // Restart attempt while busy; start+abort in idle.
        sweep_start();
        to_cycle(12); start = 1'b1;
        to_cycle(13); start = 1'b0;
        to_cycle(35); chk("s4.done", int'(done), 1);
        chk("s4.pass", int'(pass), 1);
        to_cycle(37);
        start = 1'b1; abort = 1'b1;
        to_cycle(38);
        start = 1'b0; abort = 1'b0;
        chk("s4.idle_pair", int'(busy), 0);

        // Reset mid-sweep, then a clean sweep.
        sweep_start();
        to_cycle(20);
        #1 rst_n = 1'b0;
        #1;
        chk("s5.busy", int'(busy), 0);
        chk("s5.dut_in", int'(dut_in), 0);
        chk("s5.err", int'(err_count), 0);
        chk("s5.done", int'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        sweep_start();
        to_cycle(34); chk("s5.vec7", int'(dut_in), 7);
        to_cycle(35); chk("s5.done2", int'(done), 1);
        chk("s5.pass2", int'(pass), 1);
        to_cycle(37);

        // Randomised tables, start pulses and aborts.
        repeat (3000) begin
            @(negedge clk);
            if (!busy && ($urandom % 4) == 0) begin
                dut_tab  = 8'($urandom);
                expected = ($urandom % 2) ? dut_tab : 8'($urandom);
            end
            start = (($urandom % 6) == 0);
            abort = (($urandom % 150) == 0);
        end
        @(negedge clk);
        start = 0; abort = 0;
        repeat (40) @(negedge clk);

        // One-input inverter, no init phase.
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; cyc = 1;
        chk("s6.c1_in", int'(dut_in1), 0);
        chk("s6.c1_busy", int'(busy1), 1);
        to_cycle(2); chk("s6.c2_in", int'(dut_in1), 0);
        to_cycle(3); chk("s6.c3_in", int'(dut_in1), 1);
        to_cycle(4); chk("s6.c4_done", int'(done1), 0);
        to_cycle(5); chk("s6.done", int'(done1), 1);
        chk("s6.pass", int'(pass1), 1);
        chk("s6.busy", int'(busy1), 0);
        chk("s6.err", int'(err1), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
